// File: rtl/batrider_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : batrider_pkg
//  Description : Shared definitions for the Batrider palette lookup stage:
//                palette geometry, CPU access FSM state encoding and the
//                5-bit to 8-bit colour expansion helper.
//  Revision    : 1.0  initial release
// ============================================================================
package batrider_pkg;

    // Palette geometry: 2048 words of 16 bits.
    localparam int PAL_AW    = 11;
    localparam int PAL_DEPTH = 2048;

    // CPU palette-window access FSM, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_ACCESS = 2'd1,
        CPU_RDWAIT = 2'd2,
        CPU_DONE   = 2'd3
    } cpu_state_t;

    // Replicate the top bits into the bottom so 5'h1F maps to full scale
    // (8'hFF) and 5'h00 maps to black.
    function automatic logic [7:0] expand5(input logic [4:0] c5);
        return {c5, c5[4:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/batrider_palette_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : batrider_palette_ram
//  Description : Single-port 2048x16 synchronous palette RAM. One address per
//                cycle, shared between read and write. Each byte lane is
//                written only when its enable is set. The read data is
//                registered; a write returns the previous contents on o_q.
//  Ports       : clk     - clock
//                i_we    - write strobe
//                i_be    - byte enables, [1] = bits 15:8, [0] = bits 7:0
//                i_addr  - word address
//                i_din   - write data
//                o_q     - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module batrider_palette_ram
    import batrider_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [1:0]        i_be,
    input  logic [PAL_AW-1:0] i_addr,
    input  logic [15:0]       i_din,
    output logic [15:0]       o_q
);

    // One 8-bit array per byte lane keeps each lane a plain single-port
    // memory with a single writer.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_lane
            logic [7:0] r_mem [PAL_DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge clk) begin
                if (i_we && i_be[g]) begin
                    r_mem[i_addr] <= i_din[g*8 +: 8];
                end
                r_q <= r_mem[i_addr];
            end

            assign o_q[g*8 +: 8] = r_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/batrider_palette.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : batrider_palette
//  Description : Palette lookup stage. Each PIXEL_CEN the 11-bit FINAL_PIXEL
//                index is looked up in the palette RAM and the 15-bit BGR555
//                entry is expanded to 8-bit RGB two cycles later. The same
//                single-port RAM serves the 68000 palette window through a
//                REQ/ACK handshake; pixel reads always win the port.
//  Ports       : CLK96        - sole clock
//                RESET96_N    - synchronous active-low reset
//                PIXEL_CEN    - pixel strobe (>= 4 cycles apart)
//                FINAL_PIXEL  - palette index
//                ACTIVE       - display-active flag aligned with FINAL_PIXEL
//                CPU_REQ/WE/ADDR/BE/DIN - CPU access request
//                CPU_DOUT     - CPU read data, valid with CPU_ACK
//                CPU_ACK      - CPU access complete
//                RED/GREEN/BLUE - expanded colour
//                RGB_VALID    - one-cycle pulse when RGB updates
//  Options     : BATRIDER_PAL_READBACK_EN - when defined, CPU reads return RAM
//                contents (extra RDWAIT cycle); otherwise CPU_DOUT is 0 and
//                reads complete without a RAM cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module batrider_palette
    import batrider_pkg::*;
(
    input  logic              CLK96,
    input  logic              RESET96_N,
    input  logic              PIXEL_CEN,
    input  logic [PAL_AW-1:0] FINAL_PIXEL,
    input  logic              ACTIVE,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [PAL_AW-1:0] CPU_ADDR,
    input  logic [1:0]        CPU_BE,
    input  logic [15:0]       CPU_DIN,
    output logic [15:0]       CPU_DOUT,
    output logic              CPU_ACK,
    output logic [7:0]        RED,
    output logic [7:0]        GREEN,
    output logic [7:0]        BLUE,
    output logic              RGB_VALID
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    cpu_state_t        r_state;
    cpu_state_t        w_state_next;
    logic              w_ram_we;
    logic [PAL_AW-1:0] w_ram_addr;
    logic [15:0]       w_ram_q;
    logic              w_unused_entry_msb;

    logic              r_pix_pend;
    logic              r_pix_active;
    logic              r_rgb_valid;
    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic [7:0]        r_blue;

    // ------------------------------------------------------------------
    // Port arbitration: the pixel index owns the address whenever the
    // strobe is high; otherwise the CPU address is presented. The FSM only
    // commits a CPU write in a cycle where PIXEL_CEN is low, so the two
    // never share a RAM cycle.
    // ------------------------------------------------------------------
    assign w_ram_addr = PIXEL_CEN ? FINAL_PIXEL : CPU_ADDR;

    batrider_palette_ram u_ram (
        .clk    (CLK96),
        .i_we   (w_ram_we),
        .i_be   (CPU_BE),
        .i_addr (w_ram_addr),
        .i_din  (CPU_DIN),
        .o_q    (w_ram_q)
    );

    // Bit 15 of a palette entry carries no colour information.
    assign w_unused_entry_msb = w_ram_q[15];

    // ------------------------------------------------------------------
    // CPU access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96) begin
        if (!RESET96_N) begin
            r_state <= CPU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ram_we     = 1'b0;
        case (r_state)
            CPU_IDLE: begin
                if (CPU_REQ) begin
                    w_state_next = CPU_ACCESS;
                end
            end
            CPU_ACCESS: begin
                // Wait out any pixel strobe; the first free cycle is the
                // CPU's RAM cycle. Gating with reset keeps a write that
                // coincides with reset from half-happening.
                if (!PIXEL_CEN) begin
                    w_ram_we = CPU_WE & RESET96_N;
`ifdef BATRIDER_PAL_READBACK_EN
                    w_state_next = CPU_WE ? CPU_DONE : CPU_RDWAIT;
`else
                    w_state_next = CPU_DONE;
`endif
                end
            end
            CPU_RDWAIT: begin
                w_state_next = CPU_DONE;
            end
            CPU_DONE: begin
                if (!CPU_REQ) begin
                    w_state_next = CPU_IDLE;
                end
            end
            default: begin
                w_state_next = CPU_IDLE;
            end
        endcase
    end

    assign CPU_ACK = (r_state == CPU_DONE);

    // ------------------------------------------------------------------
    // CPU readback
    // ------------------------------------------------------------------
`ifdef BATRIDER_PAL_READBACK_EN
    logic [15:0] r_cpu_dout;

    // In RDWAIT the RAM output holds the word addressed in the ACCESS
    // cycle; a pixel strobe now only affects the next cycle's q.
    always_ff @(posedge CLK96) begin
        if (!RESET96_N) begin
            r_cpu_dout <= 16'h0000;
        end else if (r_state == CPU_RDWAIT) begin
            r_cpu_dout <= w_ram_q;
        end
    end

    assign CPU_DOUT = r_cpu_dout;
`else
    assign CPU_DOUT = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Pixel path: strobe at T, RAM q at T+1, RGB and RGB_VALID at T+2.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96) begin
        if (!RESET96_N) begin
            r_pix_pend   <= 1'b0;
            r_pix_active <= 1'b0;
            r_rgb_valid  <= 1'b0;
            r_red        <= 8'h00;
            r_green      <= 8'h00;
            r_blue       <= 8'h00;
        end else begin
            r_pix_pend  <= PIXEL_CEN;
            r_rgb_valid <= r_pix_pend;
            if (PIXEL_CEN) begin
                r_pix_active <= ACTIVE;
            end
            if (r_pix_pend) begin
                // Blanked pixels still produce an update, just black.
                if (r_pix_active) begin
                    r_red   <= expand5(w_ram_q[4:0]);
                    r_green <= expand5(w_ram_q[9:5]);
                    r_blue  <= expand5(w_ram_q[14:10]);
                end else begin
                    r_red   <= 8'h00;
                    r_green <= 8'h00;
                    r_blue  <= 8'h00;
                end
            end
        end
    end

    assign RED       = r_red;
    assign GREEN     = r_green;
    assign BLUE      = r_blue;
    assign RGB_VALID = r_rgb_valid;

endmodule
`default_nettype wire

// File: tb/tb_batrider_palette.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_batrider_palette
//  Description : Scoreboard bench for batrider_palette. Stimulus tasks push
//                expected RGB values (with their due cycle) and expected CPU
//                read data into queues; a monitor on the falling clock edge
//                pops and compares whenever RGB_VALID pulses or CPU_ACK rises.
//                Works with and without BATRIDER_PAL_READBACK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_batrider_palette;

    logic        CLK96 = 1'b0;
    logic        RESET96_N;
    logic        PIXEL_CEN;
    logic [10:0] FINAL_PIXEL;
    logic        ACTIVE;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [10:0] CPU_ADDR;
    logic [1:0]  CPU_BE;
    logic [15:0] CPU_DIN;
    logic [15:0] CPU_DOUT;
    logic        CPU_ACK;
    logic [7:0]  RED;
    logic [7:0]  GREEN;
    logic [7:0]  BLUE;
    logic        RGB_VALID;

`ifdef BATRIDER_PAL_READBACK_EN
    localparam int          RD_LAT    = 3;
    localparam logic [15:0] RD5_DATA  = 16'h7C10;
    localparam logic [15:0] RD11_DATA = 16'h7C00;
`else
    localparam int          RD_LAT    = 2;
    localparam logic [15:0] RD5_DATA  = 16'h0000;
    localparam logic [15:0] RD11_DATA = 16'h0000;
`endif

    batrider_palette dut (
        .CLK96       (CLK96),
        .RESET96_N   (RESET96_N),
        .PIXEL_CEN   (PIXEL_CEN),
        .FINAL_PIXEL (FINAL_PIXEL),
        .ACTIVE      (ACTIVE),
        .CPU_REQ     (CPU_REQ),
        .CPU_WE      (CPU_WE),
        .CPU_ADDR    (CPU_ADDR),
        .CPU_BE      (CPU_BE),
        .CPU_DIN     (CPU_DIN),
        .CPU_DOUT    (CPU_DOUT),
        .CPU_ACK     (CPU_ACK),
        .RED         (RED),
        .GREEN       (GREEN),
        .BLUE        (BLUE),
        .RGB_VALID   (RGB_VALID)
    );

    always #5 CLK96 = ~CLK96;

    int cyc = 0;
    always @(posedge CLK96) cyc <= cyc + 1;

    int          checks       = 0;
    int          failures     = 0;
    int          rgb_pulses   = 0;
    int          rgb_expected = 0;
    int          cyc_req      = 0;
    logic        ack_prev     = 1'b0;
    logic [23:0] q_rgb[$];
    int          q_rgb_cyc[$];
    logic [15:0] q_dout[$];
    bit          q_isrd[$];
    logic [15:0] mon_dout;
    bit          mon_isrd;
    logic [23:0] mon_rgb;
    int          mon_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge CLK96) begin
        if (RGB_VALID) begin
            rgb_pulses++;
            if (q_rgb.size() == 0) begin
                fail_now("rgb_unexpected_pulse");
            end else begin
                mon_rgb = q_rgb.pop_front();
                mon_cyc = q_rgb_cyc.pop_front();
                check("rgb_value", 32'({RED, GREEN, BLUE}), 32'(mon_rgb));
                check("rgb_latency_cycle", 32'(cyc), 32'(mon_cyc));
            end
        end
        if (CPU_ACK && !ack_prev) begin
            if (q_dout.size() == 0) begin
                fail_now("cpu_unexpected_ack");
            end else begin
                mon_dout = q_dout.pop_front();
                mon_isrd = q_isrd.pop_front();
                if (mon_isrd) check("cpu_dout", 32'(CPU_DOUT), 32'(mon_dout));
            end
        end
        ack_prev = CPU_ACK;
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic push_rgb(input logic [23:0] exp);
        q_rgb.push_back(exp);
        q_rgb_cyc.push_back(cyc + 2);
        rgb_expected++;
    endtask

    task automatic start_req(input logic we, input logic [10:0] addr, input logic [1:0] be,
                             input logic [15:0] din, input logic [15:0] exp_dout);
        @(posedge CLK96); #1;
        CPU_REQ  = 1'b1;
        CPU_WE   = we;
        CPU_ADDR = addr;
        CPU_BE   = be;
        CPU_DIN  = din;
        q_dout.push_back(exp_dout);
        q_isrd.push_back(!we);
        cyc_req = cyc;
    endtask

    task automatic wait_ack(input string name, input int exp_lat);
        int n = 0;
        while (!CPU_ACK && n < 20) begin
            @(posedge CLK96); #1;
            n++;
        end
        check({name, "_req_to_ack"}, 32'(cyc - cyc_req), 32'(exp_lat));
    endtask

    task automatic release_req(input string name);
        @(posedge CLK96); #1;
        check({name, "_ack_hold"}, 32'(CPU_ACK), 32'd1);
        CPU_REQ = 1'b0;
        @(posedge CLK96); #1;
        check({name, "_ack_drop"}, 32'(CPU_ACK), 32'd0);
    endtask

    task automatic cpu_op(input string name, input logic we, input logic [10:0] addr,
                          input logic [1:0] be, input logic [15:0] din,
                          input logic [15:0] exp_dout, input int exp_lat);
        start_req(we, addr, be, din, exp_dout);
        wait_ack(name, exp_lat);
        release_req(name);
    endtask

    task automatic do_pixel(input string name, input logic [10:0] idx, input logic act,
                            input logic [23:0] exp);
        @(posedge CLK96); #1;
        PIXEL_CEN   = 1'b1;
        FINAL_PIXEL = idx;
        ACTIVE      = act;
        push_rgb(exp);
        @(posedge CLK96); #1;
        PIXEL_CEN = 1'b0;
        repeat (4) @(posedge CLK96);
        #1;
        check({name, "_rgb_hold"}, 32'({RED, GREEN, BLUE}), 32'(exp));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        RESET96_N   = 1'b0;
        PIXEL_CEN   = 1'b0;
        FINAL_PIXEL = '0;
        ACTIVE      = 1'b0;
        CPU_REQ     = 1'b0;
        CPU_WE      = 1'b0;
        CPU_ADDR    = '0;
        CPU_BE      = '0;
        CPU_DIN     = '0;
        repeat (3) @(posedge CLK96);
        #1;
        check("reset_rgb",       32'({RED, GREEN, BLUE}), 32'h0);
        check("reset_rgb_valid", 32'(RGB_VALID), 32'd0);
        check("reset_cpu_ack",   32'(CPU_ACK), 32'd0);
        check("reset_cpu_dout",  32'(CPU_DOUT), 32'h0);
        RESET96_N = 1'b1;

        // White at 0x123, then look it up.
        cpu_op("wr_123", 1'b1, 11'h123, 2'b11, 16'h7FFF, 16'h0, 2);
        do_pixel("px_123", 11'h123, 1'b1, 24'hFFFFFF);

        // Byte-enable merge: 0x0010 then upper byte 0x7C -> 0x7C10.
        cpu_op("wr5_full", 1'b1, 11'h005, 2'b11, 16'h0010, 16'h0, 2);
        cpu_op("wr5_hi",   1'b1, 11'h005, 2'b10, 16'h7C00, 16'h0, 2);
        cpu_op("rd5",      1'b0, 11'h005, 2'b11, 16'h0000, RD5_DATA, RD_LAT);
        do_pixel("px_5", 11'h005, 1'b1, 24'h8400FF);

        // No byte enables: acknowledged, contents unchanged.
        cpu_op("wr5_be0", 1'b1, 11'h005, 2'b00, 16'h0000, 16'h0, 2);
        cpu_op("rd5_after_be0", 1'b0, 11'h005, 2'b11, 16'h0000, RD5_DATA, RD_LAT);
        do_pixel("px_5_after_be0", 11'h005, 1'b1, 24'h8400FF);

        // Blanked pixel: black, but still a valid pulse.
        do_pixel("px_blank", 11'h123, 1'b0, 24'h000000);

        // Pixel strobe lands in the FSM's ACCESS cycle: write slips by one.
        start_req(1'b1, 11'h040, 2'b11, 16'h03E0, 16'h0);
        @(posedge CLK96); #1;
        PIXEL_CEN   = 1'b1;
        FINAL_PIXEL = 11'h123;
        ACTIVE      = 1'b1;
        push_rgb(24'hFFFFFF);
        @(posedge CLK96); #1;
        PIXEL_CEN = 1'b0;
        wait_ack("wr_collide", 3);
        release_req("wr_collide");
        repeat (2) @(posedge CLK96);
        do_pixel("px_40", 11'h040, 1'b1, 24'h00FF00);

        // Pixel read of the address written in the immediately previous cycle.
        start_req(1'b1, 11'h007, 2'b11, 16'h001F, 16'h0);
        @(posedge CLK96); #1;
        @(posedge CLK96); #1;
        PIXEL_CEN   = 1'b1;
        FINAL_PIXEL = 11'h007;
        ACTIVE      = 1'b1;
        push_rgb(24'hFF0000);
        wait_ack("wr_fwd", 2);
        @(posedge CLK96); #1;
        PIXEL_CEN = 1'b0;
        release_req("wr_fwd");
        repeat (3) @(posedge CLK96);

        // Reset while in DONE with REQ still held.
        start_req(1'b1, 11'h010, 2'b11, 16'h001F, 16'h0);
        wait_ack("wr_rst", 2);
        RESET96_N = 1'b0;
        @(posedge CLK96); #1;
        check("rst_done_ack",  32'(CPU_ACK), 32'd0);
        check("rst_done_dout", 32'(CPU_DOUT), 32'h0);
        check("rst_done_rgb",  32'({RED, GREEN, BLUE}), 32'h0);
        RESET96_N = 1'b1;
        CPU_REQ   = 1'b0;
        do_pixel("px_10_committed", 11'h010, 1'b1, 24'hFF0000);
        cpu_op("wr_after_rst", 1'b1, 11'h011, 2'b11, 16'h7C00, 16'h0, 2);
        cpu_op("rd_after_rst", 1'b0, 11'h011, 2'b11, 16'h0000, RD11_DATA, RD_LAT);
        do_pixel("px_11", 11'h011, 1'b1, 24'h0000FF);

        repeat (6) @(posedge CLK96);
        #1;
        check("rgb_queue_drained", 32'(q_rgb.size()), 32'd0);
        check("cpu_queue_drained", 32'(q_dout.size()), 32'd0);
        check("rgb_pulse_count",   32'(rgb_pulses), 32'(rgb_expected));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
